// File: rtl/sram_fifo_ctrl_pkg.sv
// rtl/sram_fifo_ctrl_pkg.sv - default sizing for the PSX byte FIFO
//
// Purpose : shared defaults for sram_fifo_ctrl and a pointer helper.
// Ports   : none (package).
package sram_fifo_ctrl_pkg;

    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_ADDR_BITS   = 4;
    localparam int DEF_ALMOST_FULL = 12;

    // Occupancy from two wrap-bit pointers; modulo arithmetic falls out of
    // the fixed operand width, so no special case is needed at roll-over.
    function automatic logic [DEF_ADDR_BITS:0] occupancy(
        input logic [DEF_ADDR_BITS:0] wr,
        input logic [DEF_ADDR_BITS:0] rd
    );
        return wr - rd;
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_fifo_pointer.sv
// rtl/sram_fifo_ctrl_fifo_pointer.sv - wrapping FIFO pointer with clear and increment
//
// Purpose : BITS-wide counter used for both the write and read pointers.
// Ports   : clk_i    clock
//           rst_ni   asynchronous active-low reset
//           clr_i    synchronous clear, wins over inc_i
//           inc_i    advance by one at the clock edge
//           ptr_o    current pointer value
//           nxt_o    value the pointer takes at the next edge
module fifo_pointer #(
    parameter int BITS = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [BITS-1:0] ptr_o,
    output logic [BITS-1:0] nxt_o
);

    logic [BITS-1:0] ptr_q;
    logic [BITS-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + BITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
    assign nxt_o = ptr_d;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - first-word-fall-through FIFO sequencer around an external dual-port SRAM
//
// Purpose : owns pointers, occupancy and both handshakes; the SRAM (async read)
//           lives outside and is driven through the ram_* ports.
// Ports   : clk, reset (async active-low), flush (sync clear)
//           in_data/in_valid/in_ready      producer side
//           out_data/out_valid/out_ready   consumer side (out_data = ram_read_data)
//           count, almost_full             status (almost_full registered)
//           ram_write_en/addr/data, ram_read_addr, ram_read_data  SRAM side
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int ALMOST_FULL = DEF_ALMOST_FULL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS:0]   count,
    output logic                 almost_full,
    output logic                 ram_write_en,
    output logic [ADDR_BITS-1:0] ram_write_addr,
    output logic [DATA_BITS-1:0] ram_write_data,
    output logic [ADDR_BITS-1:0] ram_read_addr,
    input  logic [DATA_BITS-1:0] ram_read_data
);

    localparam int PW = ADDR_BITS + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          almost_full_q;

    fifo_pointer #(.BITS(PW)) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (flush),
        .inc_i  (push),
        .ptr_o  (wr_ptr),
        .nxt_o  (wr_ptr_d)
    );

    fifo_pointer #(.BITS(PW)) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (flush),
        .inc_i  (pop),
        .ptr_o  (rd_ptr),
        .nxt_o  (rd_ptr_d)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

    // Status comes only from registered pointers, so a same-cycle pop never
    // opens in_ready and a same-cycle push never raises out_valid.
    assign in_ready  = ~full & ~flush;
    assign out_valid = ~empty & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign count   = wr_ptr - rd_ptr;
    assign count_d = wr_ptr_d - rd_ptr_d;

    assign ram_write_en   = push;
    assign ram_write_addr = wr_ptr[ADDR_BITS-1:0];
    assign ram_write_data = in_data;
    assign ram_read_addr  = rd_ptr[ADDR_BITS-1:0];
    assign out_data       = ram_read_data;

    // Computed from next-state occupancy so the flag lands on the same edge
    // as the count it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= PW'(ALMOST_FULL));
        end
    end

    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - directed self-checking bench for sram_fifo_ctrl
module tb_sram_fifo_ctrl;

    localparam int DB = 8;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [DB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AB:0]   count;
    logic          almost_full;
    logic          ram_write_en;
    logic [AB-1:0] ram_write_addr;
    logic [DB-1:0] ram_write_data;
    logic [AB-1:0] ram_read_addr;
    logic [DB-1:0] ram_read_data;

    logic [DB-1:0] mem [0:(1<<AB)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
    end
    assign ram_read_data = mem[ram_read_addr];

    sram_fifo_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .almost_full    (almost_full),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_wr_en", 32'(ram_write_en), 0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_count", 32'(count), 0);

        // Three pushes with the consumer stalled, then drain in order
        in_valid = 1'b1;
        in_data  = 8'h11;
        #1;
        check("p1_no_bypass", 32'(out_valid), 0);
        check("p1_wr_en", 32'(ram_write_en), 1);
        check("p1_wr_addr", 32'(ram_write_addr), 0);
        tick();
        check("p1_out_valid", 32'(out_valid), 1);
        check("p1_head", 32'(out_data), 32'h11);
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        check("p3_count", 32'(count), 3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pop_data", 32'(out_data), 32'h11 * (i + 1));
            check("pop_count", 32'(count), 3 - i);
            tick();
        end
        check("drain_count", 32'(count), 0);
        check("drain_out_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Fill to 16; almost_full tracks count >= 12 on the same edge
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            tick();
            check("fill_count", 32'(count), i + 1);
            check("fill_af", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
        end
        in_data = 8'hEE;
        #1;
        check("full_in_ready", 32'(in_ready), 0);
        check("full_wr_en", 32'(ram_write_en), 0);
        tick();
        check("full_hold_count", 32'(count), 16);

        // Full with push and pop requested: only the pop happens
        in_data   = 8'hB0;
        out_ready = 1'b1;
        #1;
        check("fp_in_ready", 32'(in_ready), 0);
        check("fp_head", 32'(out_data), 32'hA0);
        tick();
        check("fp_count", 32'(count), 15);
        check("fp_af", 32'(almost_full), 1);
        out_ready = 1'b0;
        #1;
        check("fp_retry_wr_en", 32'(ram_write_en), 1);
        tick();
        in_valid = 1'b0;
        check("fp_refill_count", 32'(count), 16);

        // Drain: A1..AF then B0
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("drain16_data", 32'(out_data), (i < 15) ? (32'hA1 + i) : 32'hB0);
            tick();
        end
        out_ready = 1'b0;
        check("drain16_count", 32'(count), 0);
        check("drain16_af", 32'(almost_full), 0);

        // Sustained push+pop across pointer wrap
        in_valid = 1'b1;
        in_data  = 8'h40;
        tick();
        check("stream_prime", 32'(count), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'h41 + 8'(i);
            #1;
            check("stream_data", 32'(out_data), 32'h40 + i);
            check("stream_ready", 32'(in_ready & out_valid), 1);
            tick();
            check("stream_count", 32'(count), 1);
        end
        in_valid = 1'b0;
        #1;
        check("stream_last", 32'(out_data), 32'h68);
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 0);

        // Flush with a write attempt in the same cycle
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h50 + 8'(i);
            tick();
        end
        check("pre_flush_count", 32'(count), 5);
        flush   = 1'b1;
        in_data = 8'hFF;
        #1;
        check("flush_wr_en", 32'(ram_write_en), 0);
        check("flush_in_ready", 32'(in_ready), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("post_flush_count", 32'(count), 0);
        check("post_flush_out_valid", 32'(out_valid), 0);
        check("post_flush_af", 32'(almost_full), 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        check("post_flush_head", 32'(out_data), 32'h77);

        // Asynchronous reset mid-burst
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        tick();
        reset = 1'b1;
        tick();
        check("after_rst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
